jt5205_mch: RTL and testbench

// - NCH-channel MSM5205-style 4-bit ADPCM decoder; one shared, time-multiplexed decode engine.
// - Per-channel nibble FIFO with a valid/ready push port and a per-channel sample-rate divider.
// - Outputs per-channel 12-bit sound plus a saturation-free mixed sum.
// - Sits between the sound-CPU/ROM fetch logic and the board audio mixer.

---
 rtl/jt5205_mch_if.sv | 14 +
 rtl/jt5205_mch.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_jt5205_mch.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/jt5205_mch_if.sv
// Push port of the multi-channel ADPCM decoder: one 4-bit nibble plus its
// target channel, transferred on din_valid & din_ready. The decoder is the
// slave; din_ready depends combinationally on din_ch.
interface jt5205_mch_if #(
    parameter int CHW = 2
) ();
    logic [3:0]     din;
    logic [CHW-1:0] din_ch;
    logic           din_valid;
    logic           din_ready;

    modport master (output din, output din_ch, output din_valid, input din_ready);
    modport slave  (input din, input din_ch, input din_valid, output din_ready);
endinterface

// File: rtl/jt5205_mch.sv
// jt5205_mch: NCH-channel MSM5205-style 4-bit ADPCM decoder.
// Per-channel nibble FIFO and sample-rate divider feed one shared decode
// engine that serves one channel per 6-clk pass (round-robin). Per-channel
// 12-bit saturated samples plus a registered mixed sum.
// Optional feature: define JT5205_MCH_INTERP_EN to average each mix sum with
// the previous one (half-sample linear interpolation).
module jt5205_mch #(
    parameter int NCH  = 4,
    parameter int FAW  = 2,
    parameter int CHW  = 2,
    parameter int MIXW = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cen,
    input  logic [2*NCH-1:0]       sel,
    input  logic [NCH-1:0]         ch_en,
    jt5205_mch_if.slave            push,
    output logic [12*NCH-1:0]      sound,
    output logic [NCH-1:0]         sample,
    output logic [NCH-1:0]         underrun,
    output logic [NCH-1:0]         overrun,
    output logic signed [MIXW-1:0] mix,
    output logic                   mix_sample
);
    localparam int           DEPTH = 2**FAW;
    localparam logic [FAW:0] FULL  = (FAW+1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACC0, S_ACC1, S_ACC2, S_STORE} state_t;

    function automatic logic [10:0] delta(input logic [5:0] i);
        case (i)
            6'd0:  delta = 11'd16;   6'd1:  delta = 11'd17;   6'd2:  delta = 11'd19;
            6'd3:  delta = 11'd21;   6'd4:  delta = 11'd23;   6'd5:  delta = 11'd25;
            6'd6:  delta = 11'd28;   6'd7:  delta = 11'd31;   6'd8:  delta = 11'd34;
            6'd9:  delta = 11'd37;   6'd10: delta = 11'd41;   6'd11: delta = 11'd45;
            6'd12: delta = 11'd50;   6'd13: delta = 11'd55;   6'd14: delta = 11'd60;
            6'd15: delta = 11'd66;   6'd16: delta = 11'd73;   6'd17: delta = 11'd80;
            6'd18: delta = 11'd88;   6'd19: delta = 11'd97;   6'd20: delta = 11'd107;
            6'd21: delta = 11'd118;  6'd22: delta = 11'd130;  6'd23: delta = 11'd143;
            6'd24: delta = 11'd157;  6'd25: delta = 11'd173;  6'd26: delta = 11'd190;
            6'd27: delta = 11'd209;  6'd28: delta = 11'd230;  6'd29: delta = 11'd253;
            6'd30: delta = 11'd279;  6'd31: delta = 11'd307;  6'd32: delta = 11'd337;
            6'd33: delta = 11'd371;  6'd34: delta = 11'd408;  6'd35: delta = 11'd449;
            6'd36: delta = 11'd494;  6'd37: delta = 11'd544;  6'd38: delta = 11'd598;
            6'd39: delta = 11'd658;  6'd40: delta = 11'd724;  6'd41: delta = 11'd796;
            6'd42: delta = 11'd876;  6'd43: delta = 11'd963;  6'd44: delta = 11'd1060;
            6'd45: delta = 11'd1166; 6'd46: delta = 11'd1282; 6'd47: delta = 11'd1411;
            default: delta = 11'd1552;
        endcase
    endfunction

    function automatic logic [6:0] lim_of(input logic [1:0] s);
        case (s)
            2'd0:    lim_of = 7'd95;
            2'd1:    lim_of = 7'd63;
            default: lim_of = 7'd47;
        endcase
    endfunction

    // divider / pending state
    logic [6:0]     cnt_q [NCH];
    logic [NCH-1:0] pend_q, overrun_q, tick_d, pend_clr_d;
    // FIFO state
    logic [3:0]     mem_q  [NCH][DEPTH];
    logic [FAW-1:0] wp_q   [NCH];
    logic [FAW-1:0] rp_q   [NCH];
    logic [FAW:0]   fcnt_q [NCH];
    logic [NCH-1:0] push_v_d, pop_v_d;
    logic           rdy_d, pop_d;
    // engine state
    state_t                state_q;
    logic [CHW-1:0]        ch_q, last_q, pick_ch_d;
    logic                  pick_vld_d;
    logic [3:0]            nib_q;
    logic [10:0]           d_q, dcur_d;
    logic [12:0]           acc_q;
    logic signed [11:0]    snd_q [NCH];
    logic [5:0]            idx_q [NCH];
    logic [NCH-1:0]        sample_q, underrun_q;
    logic                  cur_en;
    logic [FAW:0]          cur_cnt;
    logic [3:0]            cur_head;
    logic [5:0]            cur_idx, idx_d;
    logic signed [11:0]    cur_snd, sat_d;
    logic signed [13:0]    ext_d, qv_d, y_d;
    logic signed [7:0]     step_d, nidx_d;
    // mix state
    logic                  mix_pend_q, mix_sample_q;
    logic signed [MIXW-1:0] mix_q, sum_d;
`ifdef JT5205_MCH_INTERP_EN
    logic signed [MIXW-1:0] prev_q;
`endif

    // rate tick: counter reaches the selected limit on an enabled cen
    always_comb begin
        tick_d = '0;
        for (int unsigned k = 0; k < NCH; k++)
            tick_d[k] = cen && ch_en[k] && (sel[2*k +: 2] != 2'd3)
                        && (cnt_q[k] == lim_of(sel[2*k +: 2]));
    end

    // per-channel rate counters, pending-request flags and overrun pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NCH; k++) cnt_q[k] <= '0;
            pend_q    <= '0;
            overrun_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (!ch_en[k] || sel[2*k +: 2] == 2'd3) cnt_q[k] <= '0;
                else if (cen) cnt_q[k] <= tick_d[k] ? 7'd0 : cnt_q[k] + 7'd1;
                if (!ch_en[k])          pend_q[k] <= 1'b0;
                else if (tick_d[k])     pend_q[k] <= 1'b1;
                else if (pend_clr_d[k]) pend_q[k] <= 1'b0;
                overrun_q[k] <= tick_d[k] && pend_q[k];
            end
        end
    end

    // push readiness and per-channel push/pop strobes
    always_comb begin
        rdy_d    = 1'b0;
        push_v_d = '0;
        pop_v_d  = '0;
        for (int unsigned k = 0; k < NCH; k++)
            if (push.din_ch == CHW'(k)) rdy_d = ch_en[k] && (fcnt_q[k] != FULL);
        for (int unsigned k = 0; k < NCH; k++) begin
            push_v_d[k] = push.din_valid && rdy_d && (push.din_ch == CHW'(k));
            pop_v_d[k]  = pop_d && (ch_q == CHW'(k));
        end
    end
    assign push.din_ready = rdy_d;

    // nibble FIFOs; a disabled channel is flushed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                wp_q[k] <= '0; rp_q[k] <= '0; fcnt_q[k] <= '0;
                for (int unsigned j = 0; j < DEPTH; j++) mem_q[k][j] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (!ch_en[k]) begin
                    wp_q[k] <= '0; rp_q[k] <= '0; fcnt_q[k] <= '0;
                end else begin
                    if (push_v_d[k]) begin
                        mem_q[k][wp_q[k]] <= push.din;
                        wp_q[k] <= wp_q[k] + 1'b1;
                    end
                    if (pop_v_d[k]) rp_q[k] <= rp_q[k] + 1'b1;
                    if (push_v_d[k] && !pop_v_d[k])      fcnt_q[k] <= fcnt_q[k] + 1'b1;
                    else if (!push_v_d[k] && pop_v_d[k]) fcnt_q[k] <= fcnt_q[k] - 1'b1;
                end
            end
        end
    end

    // round-robin pick, view of the channel in service, STORE arithmetic
    always_comb begin
        logic           hi_vld, lo_vld;
        logic [CHW-1:0] hi_ch, lo_ch;
        hi_vld = 1'b0; lo_vld = 1'b0; hi_ch = '0; lo_ch = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (pend_q[k] && !lo_vld) begin lo_vld = 1'b1; lo_ch = CHW'(k); end
            if (pend_q[k] && !hi_vld && CHW'(k) > last_q) begin hi_vld = 1'b1; hi_ch = CHW'(k); end
        end
        pick_vld_d = lo_vld;
        pick_ch_d  = hi_vld ? hi_ch : lo_ch;

        cur_en = 1'b0; cur_cnt = '0; cur_head = '0; cur_idx = '0; cur_snd = '0;
        for (int unsigned k = 0; k < NCH; k++)
            if (ch_q == CHW'(k)) begin
                cur_en   = ch_en[k];
                cur_cnt  = fcnt_q[k];
                cur_head = mem_q[k][rp_q[k]];
                cur_idx  = idx_q[k];
                cur_snd  = snd_q[k];
            end
        pop_d  = (state_q == S_LOAD) && cur_en && (cur_cnt != '0);
        dcur_d = delta(cur_idx);

        pend_clr_d = '0;
        for (int unsigned k = 0; k < NCH; k++)
            if (ch_q == CHW'(k))
                pend_clr_d[k] = (state_q == S_STORE) || (state_q == S_LOAD && !pop_d);

        ext_d = {{2{cur_snd[11]}}, cur_snd};
        qv_d  = {1'b0, acc_q};
        y_d   = nib_q[3] ? ext_d - qv_d : ext_d + qv_d;
        if (y_d > 14'sd2047)       sat_d = 12'sd2047;
        else if (y_d < -14'sd2048) sat_d = -12'sd2048;
        else                       sat_d = y_d[11:0];

        if (nib_q[2]) step_d = 8'sd2 + $signed({5'd0, nib_q[1:0], 1'b0});
        else          step_d = -8'sd1;
        nidx_d = $signed({2'b00, cur_idx}) + step_d;
        if (nidx_d < 8'sd0)       idx_d = 6'd0;
        else if (nidx_d > 8'sd48) idx_d = 6'd48;
        else                      idx_d = nidx_d[5:0];
    end

    // decode engine: one channel per pass; disabling the channel aborts the pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ch_q <= '0; last_q <= '0; nib_q <= '0; d_q <= '0; acc_q <= '0;
            sample_q <= '0; underrun_q <= '0;
            for (int unsigned k = 0; k < NCH; k++) begin snd_q[k] <= '0; idx_q[k] <= '0; end
        end else begin
            sample_q   <= '0;
            underrun_q <= '0;
            if (state_q != S_IDLE && !cur_en) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: if (pick_vld_d) begin
                        ch_q    <= pick_ch_d;
                        last_q  <= pick_ch_d;
                        state_q <= S_LOAD;
                    end
                    S_LOAD: if (!pop_d) begin
                        for (int unsigned k = 0; k < NCH; k++)
                            if (ch_q == CHW'(k)) underrun_q[k] <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        nib_q   <= cur_head;
                        d_q     <= dcur_d;
                        acc_q   <= {5'd0, dcur_d[10:3]};
                        state_q <= S_ACC0;
                    end
                    S_ACC0: begin
                        if (nib_q[2]) acc_q <= acc_q + {2'd0, d_q};
                        state_q <= S_ACC1;
                    end
                    S_ACC1: begin
                        if (nib_q[1]) acc_q <= acc_q + {3'd0, d_q[10:1]};
                        state_q <= S_ACC2;
                    end
                    S_ACC2: begin
                        if (nib_q[0]) acc_q <= acc_q + {4'd0, d_q[10:2]};
                        state_q <= S_STORE;
                    end
                    S_STORE: begin
                        for (int unsigned k = 0; k < NCH; k++)
                            if (ch_q == CHW'(k)) begin
                                snd_q[k]    <= sat_d;
                                idx_q[k]    <= idx_d;
                                sample_q[k] <= 1'b1;
                            end
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
            for (int unsigned k = 0; k < NCH; k++)
                if (!ch_en[k]) begin snd_q[k] <= '0; idx_q[k] <= '0; end
        end
    end

    // sign-extended sum of all channel samples
    always_comb begin
        sum_d = '0;
        for (int unsigned k = 0; k < NCH; k++)
            sum_d = sum_d + {{(MIXW-12){snd_q[k][11]}}, snd_q[k]};
    end

    // mix register, updated one clk after each completed STORE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_pend_q   <= 1'b0;
            mix_sample_q <= 1'b0;
            mix_q        <= '0;
`ifdef JT5205_MCH_INTERP_EN
            prev_q       <= '0;
`endif
        end else begin
            mix_pend_q   <= (state_q == S_STORE) && cur_en;
            mix_sample_q <= mix_pend_q;
            if (mix_pend_q) begin
`ifdef JT5205_MCH_INTERP_EN
                mix_q  <= (prev_q >>> 1) + (sum_d >>> 1);
                prev_q <= sum_d;
`else
                mix_q  <= sum_d;
`endif
            end
        end
    end

    // output packing
    always_comb begin
        sound = '0;
        for (int unsigned k = 0; k < NCH; k++) sound[12*k +: 12] = snd_q[k];
    end
    assign sample     = sample_q;
    assign underrun   = underrun_q;
    assign overrun    = overrun_q;
    assign mix        = mix_q;
    assign mix_sample = mix_sample_q;
endmodule

// File: tb/tb_jt5205_mch.sv
// Directed bench for jt5205_mch (NCH=4, FAW=2, CHW=2, MIXW=14).
module tb_jt5205_mch;
    logic               clk;
    logic               rst_n;
    logic               cen;
    logic [7:0]         sel;
    logic [3:0]         ch_en;
    logic [47:0]        sound;
    logic [3:0]         sample, underrun, overrun;
    logic signed [13:0] mix;
    logic               mix_sample;
    int                 n_cmp = 0;
    int                 n_err = 0;

`ifdef JT5205_MCH_INTERP_EN
    localparam int MIX_EXP = 105;
`else
    localparam int MIX_EXP = 120;
`endif

    jt5205_mch_if #(.CHW(2)) bif ();

    jt5205_mch #(.NCH(4), .FAW(2), .CHW(2), .MIXW(14)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .sel(sel), .ch_en(ch_en),
        .push(bif), .sound(sound), .sample(sample), .underrun(underrun),
        .overrun(overrun), .mix(mix), .mix_sample(mix_sample)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0; cen = 1'b1; sel = '1; ch_en = '0;
        bif.din = '0; bif.din_ch = '0; bif.din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic push_nib(input int ch, input logic [3:0] n);
        int t;
        t = 0;
        bif.din = n; bif.din_ch = 2'(ch); bif.din_valid = 1'b1;
        @(negedge clk);
        while (!bif.din_ready && t < 400) begin @(negedge clk); t++; end
        n_cmp++;
        if (bif.din_ready !== 1'b1) begin
            n_err++;
            $display("FAIL push_ready ch%0d: din_ready=%b required=1", ch, bif.din_ready);
        end
        @(posedge clk); #1;
        bif.din_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int k, input bit is_ur, input int budget,
                              output int cyc, output bit got);
        got = 1'b0; cyc = 0;
        while (!got && cyc < budget) begin
            @(posedge clk); #1; cyc++;
            if (is_ur ? underrun[k] : sample[k]) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cen = 1'b1; sel = '0; ch_en = '0;
        bif.din = '0; bif.din_ch = '0; bif.din_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        n_cmp++; if (sound !== '0) begin n_err++; $display("FAIL reset_sound: got=%h required=0", sound); end
        n_cmp++; if (mix !== '0) begin n_err++; $display("FAIL reset_mix: got=%0d required=0", mix); end
        n_cmp++; if ({sample, underrun, overrun, mix_sample} !== '0) begin
            n_err++; $display("FAIL reset_pulses: got=%b required=0", {sample, underrun, overrun, mix_sample});
        end
        n_cmp++; if (bif.din_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got=%b required=0", bif.din_ready); end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_first_sample();
        int cyc; bit got; logic signed [11:0] s;
        do_reset();
        sel[1:0] = 2'd0; ch_en[0] = 1'b1;
        push_nib(0, 4'h0);
        wait_pulse(0, 1'b0, 300, cyc, got);
        s = sound[11:0];
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL first_sample_pulse: got=%b required=1", got); end
        n_cmp++; if (s !== 12'sd2) begin n_err++; $display("FAIL first_sample_value: got=%0d required=2", s); end
        wait_pulse(0, 1'b1, 300, cyc, got);
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL empty_underrun0: got=%b required=1", got); end
        wait_pulse(0, 1'b1, 300, cyc, got);
        n_cmp++; if (cyc !== 96) begin n_err++; $display("FAIL period_div96: got=%0d required=96", cyc); end
        s = sound[11:0];
        n_cmp++; if (s !== 12'sd2) begin n_err++; $display("FAIL underrun_hold0: got=%0d required=2", s); end
    endtask

    task automatic test_step();
        int cyc; bit got; logic signed [11:0] s;
        do_reset();
        sel[1:0] = 2'd0; ch_en[0] = 1'b1;
        push_nib(0, 4'h7);
        push_nib(0, 4'hF);
        wait_pulse(0, 1'b0, 300, cyc, got);
        s = sound[11:0];
        n_cmp++; if (s !== 12'sd30) begin n_err++; $display("FAIL step_up7: got=%0d required=30", s); end
        wait_pulse(0, 1'b0, 300, cyc, got);
        s = sound[11:0];
        n_cmp++; if (s !== -12'sd33) begin n_err++; $display("FAIL step_downF: got=%0d required=-33", s); end
    endtask

    task automatic test_saturate();
        int cyc; bit got; logic signed [11:0] s;
        int exp_v [8] = '{30, 93, 229, 522, 1153, 2047, 2047, 2047};
        do_reset();
        sel[1:0] = 2'd0; ch_en[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_nib(0, 4'h7);
            wait_pulse(0, 1'b0, 300, cyc, got);
            s = sound[11:0];
            n_cmp++;
            if (s !== 12'(exp_v[i])) begin
                n_err++; $display("FAIL saturate_step%0d: got=%0d required=%0d", i, s, exp_v[i]);
            end
        end
    endtask

    task automatic test_underrun();
        int cyc, nsamp; bit got;
        do_reset();
        sel[3:2] = 2'd2; ch_en[1] = 1'b1;
        wait_pulse(1, 1'b1, 200, cyc, got);
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL underrun1_first: got=%b required=1", got); end
        nsamp = 0; got = 1'b0; cyc = 0;
        while (!got && cyc < 100) begin
            @(posedge clk); #1; cyc++;
            if (sample[1]) nsamp++;
            if (underrun[1]) got = 1'b1;
        end
        n_cmp++; if (cyc !== 48) begin n_err++; $display("FAIL underrun1_period: got=%0d required=48", cyc); end
        n_cmp++; if (nsamp !== 0) begin n_err++; $display("FAIL underrun1_nosample: got=%0d required=0", nsamp); end
        n_cmp++; if (sound[23:12] !== 12'd0) begin n_err++; $display("FAIL underrun1_sound: got=%0d required=0", sound[23:12]); end
    endtask

    task automatic test_mix();
        int nmix, novr; logic signed [13:0] last;
        do_reset();
        sel = 8'h00; ch_en = 4'hF;
        for (int k = 0; k < 4; k++) push_nib(k, 4'h7);
        nmix = 0; novr = 0; last = '0;
        for (int t = 0; t < 250; t++) begin
            @(posedge clk); #1;
            if (mix_sample) begin nmix++; last = mix; end
            if (overrun !== 4'd0) novr++;
        end
        n_cmp++; if (nmix !== 4) begin n_err++; $display("FAIL mix_count: got=%0d required=4", nmix); end
        n_cmp++; if (last !== 14'(MIX_EXP)) begin n_err++; $display("FAIL mix_value: got=%0d required=%0d", last, MIX_EXP); end
        n_cmp++; if (novr !== 0) begin n_err++; $display("FAIL mix_no_overrun: got=%0d required=0", novr); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (sound[12*k +: 12] !== 12'd30) begin
                n_err++; $display("FAIL mix_sound%0d: got=%0d required=30", k, sound[12*k +: 12]);
            end
        end
    endtask

    task automatic test_fifo_full();
        int cyc; bit got; logic signed [11:0] s;
        do_reset();
        sel[5:4] = 2'd3; ch_en[2] = 1'b1;
        for (int i = 0; i < 4; i++) push_nib(2, 4'h0);
        n_cmp++; if (bif.din_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got=%b required=0", bif.din_ready); end
        bif.din = 4'h7; bif.din_valid = 1'b1;
        @(posedge clk); #1;
        bif.din_valid = 1'b0;
        sel[5:4] = 2'd0;
        for (int i = 0; i < 4; i++) begin
            wait_pulse(2, 1'b0, 200, cyc, got);
            s = sound[35:24];
            n_cmp++;
            if (s !== 12'(2 * (i + 1))) begin
                n_err++; $display("FAIL full_drain%0d: got=%0d required=%0d", i, s, 2 * (i + 1));
            end
        end
        wait_pulse(2, 1'b1, 200, cyc, got);
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL full_dropped5th: underrun=%b required=1", got); end
        sel[5:4] = 2'd3;
        push_nib(2, 4'h7);
        push_nib(2, 4'h7);
        ch_en[2] = 1'b0;
        repeat (2) @(posedge clk); #1;
        n_cmp++; if (sound[35:24] !== 12'd0) begin n_err++; $display("FAIL disable_sound: got=%0d required=0", sound[35:24]); end
        n_cmp++; if (bif.din_ready !== 1'b0) begin n_err++; $display("FAIL disable_ready: got=%b required=0", bif.din_ready); end
        ch_en[2] = 1'b1;
        #1;
        n_cmp++; if (bif.din_ready !== 1'b1) begin n_err++; $display("FAIL reenable_ready: got=%b required=1", bif.din_ready); end
        sel[5:4] = 2'd0;
        wait_pulse(2, 1'b1, 200, cyc, got);
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL flush_underrun: got=%b required=1", got); end
        n_cmp++; if (sound[35:24] !== 12'd0) begin n_err++; $display("FAIL flush_sound: got=%0d required=0", sound[35:24]); end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_step();
        test_saturate();
        test_underrun();
        test_mix();
        test_fifo_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
